// File: rtl/mem_pkg.sv
// mem_pkg: shared scratch-memory geometry (DATA_W, ADDR_W, MEM_DEPTH) and the client-id type
package mem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int MEM_DEPTH = 16;
  typedef logic client_t;
endpackage

// File: rtl/mem_port_bridge.sv
// mem_port_bridge: maps mem_en/mem_we/mem_addr/mem_wdata onto memory pins r_w/en/addr/data (inout, driven only on writes) and registers read data into mem_rdata one cycle after a read
module mem_port_bridge #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              r_w,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);
  import mem_pkg::*;
  logic wr;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  assign wr = mem_en & mem_we;
  assign data = wr ? mem_wdata : {DATA_W{1'bz}};
  always_comb begin
    r_w = ~wr;
    en = mem_en;
    addr = mem_addr;
    rdata_d = (mem_en & ~mem_we) ? data : rdata_q;
    mem_rdata = rdata_q;
  end
  always_ff @(posedge clk) rdata_q <= reset ? '0 : rdata_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-client arbiter with locked bursts for the 16x8 scratch memory; ports: cN_req/we/lock/addr/wdata in, cN_gnt/cN_rvalid/rdata out, mem_en/we/addr/wdata out, mem_rdata in
module mem_arbiter #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic              c0_lock,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic              c1_lock,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_pkg::*;
  client_t last_q, last_d, owner_q, owner_d, sel;
  logic owner_valid_q, owner_valid_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [1:0] rd_pend_q, rd_pend_d;
  logic any, keep, owner_req, other_req, sel_we, sel_lock, take;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  always_comb begin
    owner_req = owner_q ? c1_req : c0_req;
    other_req = owner_q ? c0_req : c1_req;
    any = ~reset & (c0_req | c1_req);
    keep = owner_valid_q & owner_req & (~other_req | (burst_cnt_q < 4'(MAX_BURST)));
    sel = keep ? owner_q : (c0_req & c1_req) ? ~last_q : c1_req;
    sel_we = sel ? c1_we : c0_we;
    sel_lock = sel ? c1_lock : c0_lock;
    sel_addr = sel ? c1_addr : c0_addr;
    sel_wdata = sel ? c1_wdata : c0_wdata;
    c0_gnt = any & ~sel;
    c1_gnt = any & sel;
    mem_en = any;
    mem_we = any & sel_we;
    mem_addr = any ? sel_addr : '0;
    mem_wdata = any ? sel_wdata : '0;
    take = any & sel_lock;
    last_d = any ? sel : last_q;
    owner_d = take ? sel : owner_q;
    owner_valid_d = take;
    // count saturates at MAX_BURST; the handover decision only needs "reached the limit"
    burst_cnt_d = ~take ? 4'd0 :
                  ~(owner_valid_q & (owner_q == sel)) ? 4'd1 :
                  (burst_cnt_q < 4'(MAX_BURST)) ? burst_cnt_q + 4'd1 : burst_cnt_q;
    rd_pend_d = {c1_gnt & ~c1_we, c0_gnt & ~c0_we};
    c0_rvalid = ~reset & rd_pend_q[0];
    c1_rvalid = ~reset & rd_pend_q[1];
    rdata = (c0_rvalid | c1_rvalid) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
      owner_q <= 1'b0;
      owner_valid_q <= 1'b0;
      burst_cnt_q <= 4'd0;
      rd_pend_q <= 2'b00;
    end else begin
      last_q <= last_d;
      owner_q <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random stimulus against a behavioural arbitration and memory model
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int MAX_BURST = 4;
  logic clk = 1'b0;
  logic reset;
  logic c0_req, c0_we, c0_lock, c1_req, c1_we, c1_lock;
  logic [ADDR_W-1:0] c0_addr, c1_addr, mem_addr, pin_addr;
  logic [DATA_W-1:0] c0_wdata, c1_wdata, rdata, mem_wdata, mem_rdata;
  logic c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, mem_en, mem_we, pin_r_w, pin_en;
  wire [DATA_W-1:0] dq;
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  int checks = 0;
  int failures = 0;
  int m_last, m_owner, m_streak;
  int wt [2];
  bit m_pend [2];
  logic [DATA_W-1:0] m_pdata;
  logic [DATA_W-1:0] m_mem [MEM_DEPTH];
  always #5 clk = ~clk;
  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  mem_port_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bridge (
    .clk(clk), .reset(reset), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .r_w(pin_r_w), .en(pin_en), .addr(pin_addr), .data(dq)
  );
  assign dq = (pin_en & pin_r_w) ? ram[pin_addr] : {DATA_W{1'bz}};
  always @(posedge clk) if (pin_en & ~pin_r_w) ram[pin_addr] <= dq;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit rst, input bit q0, input bit w0, input bit k0, input logic [3:0] a0,
                     input logic [7:0] d0, input bit q1, input bit w1, input bit k1,
                     input logic [3:0] a1, input logic [7:0] d1);
    bit rq [2];
    bit we [2];
    bit lk [2];
    bit dg [2];
    logic [3:0] ad [2];
    logic [7:0] wd [2];
    logic [15:0] bus;
    int g;
    rq[0] = q0; we[0] = w0; lk[0] = k0; ad[0] = a0; wd[0] = d0;
    rq[1] = q1; we[1] = w1; lk[1] = k1; ad[1] = a1; wd[1] = d1;
    reset = rst;
    c0_req = q0; c0_we = w0; c0_lock = k0; c0_addr = a0; c0_wdata = d0;
    c1_req = q1; c1_we = w1; c1_lock = k1; c1_addr = a1; c1_wdata = d1;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (m_owner >= 0 && rq[m_owner] && (!rq[1-m_owner] || m_streak < MAX_BURST)) g = m_owner;
      else if (q0 && q1) g = 1 - m_last;
      else if (q0) g = 0;
      else if (q1) g = 1;
    end
    bus = (g < 0) ? 16'h0 : {2'b00, 1'b1, we[g], ad[g], wd[g]};
    chk("gnt", {14'h0, c1_gnt, c0_gnt}, {14'h0, g == 1, g == 0});
    chk("mem_bus", {2'b00, mem_en, mem_we, mem_addr, mem_wdata}, bus);
    chk("rvalid", {14'h0, c1_rvalid, c0_rvalid}, {14'h0, !rst && m_pend[1], !rst && m_pend[0]});
    chk("rdata", {8'h0, rdata}, (!rst && (m_pend[0] || m_pend[1])) ? {8'h0, m_pdata} : 16'h0);
    dg[0] = c0_gnt; dg[1] = c1_gnt;
    for (int n = 0; n < 2; n++) begin
      wt[n] = (!rst && rq[n] && !dg[n]) ? wt[n] + 1 : 0;
      chk(n == 0 ? "starve0" : "starve1", {15'h0, wt[n] <= MAX_BURST}, 16'h1);
    end
    m_pend[0] = 0; m_pend[1] = 0;
    if (rst) begin
      m_last = 1; m_owner = -1; m_streak = 0;
    end else if (g >= 0) begin
      m_last = g;
      if (lk[g]) begin
        m_streak = (m_owner == g) ? m_streak + 1 : 1;
        m_owner = g;
      end else begin
        m_owner = -1; m_streak = 0;
      end
      if (we[g]) m_mem[ad[g]] = wd[g];
      else begin
        m_pend[g] = 1;
        m_pdata = m_mem[ad[g]];
      end
    end else begin
      m_owner = -1; m_streak = 0;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    m_last = 1; m_owner = -1; m_streak = 0; wt[0] = 0; wt[1] = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_pdata = '0;
    cyc(1, 1,0,0,4'd0,8'd0, 1,0,0,4'd0,8'd0);
    cyc(1, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < MEM_DEPTH; i++) cyc(0, 1,1,0,4'(i),8'(i*29+7), 0,0,0,4'd0,8'd0);
    cyc(0, 1,1,0,4'd3,8'hA5, 0,0,0,4'd0,8'd0);
    cyc(0, 1,0,0,4'd3,8'h00, 0,0,0,4'd0,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    cyc(1, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < 6; i++) cyc(0, 1,0,0,4'(i),8'd0, 1,0,0,4'(i+8),8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < 12; i++) cyc(0, 1,0,1,4'(i),8'd0, 1,0,0,4'd15,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < 10; i++) cyc(0, 1,0,1,4'(i),8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < 6; i++) cyc(0, 1,0,1,4'(i),8'd0, 1,0,0,4'd7,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 1,0,0,4'd5,8'd0);
    cyc(1, 0,0,0,4'd0,8'd0, 1,0,0,4'd6,8'd0);
    cyc(0, 1,0,0,4'd1,8'd0, 1,0,0,4'd2,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 1,1,0,4'd9,8'h3C);
    cyc(0, 1,0,0,4'd9,8'd0, 0,0,0,4'd0,8'd0);
    cyc(0, 0,0,0,4'd0,8'd0, 0,0,0,4'd0,8'd0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 8'($urandom),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
